// File: rtl/sum_bin_to_bcd_seq_pkg.sv
// Shared definitions for the adder / BCD conversion / display pipeline.
package sum_bin_to_bcd_seq_pkg;

  localparam int unsigned SUM_W      = 9;
  localparam int unsigned BCD_DIGITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sum_bin_to_bcd_seq_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/sum_bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock,
// with start/busy/done handshake and a result held between conversions.
module sum_bin_to_bcd_seq
  import sum_bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = SUM_W,
  parameter int unsigned DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = 4 * DIGITS;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    scratch_adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (scratch[4*g +: 4]),
      .adj   (scratch_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_SHIFT;
      ST_SHIFT: if (cnt == CW'(1)) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Scratch digits shift in from the top of shreg after per-digit correction.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      shreg   <= '0;
      scratch <= '0;
      bcd     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
          end
        end
        ST_SHIFT: begin
          scratch <= {scratch_adj[BW-2:0], shreg[WIDTH-1]};
          shreg   <= shreg << 1;
          cnt     <= cnt - CW'(1);
        end
        ST_DONE: begin
          bcd  <= scratch;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_sum_bin_to_bcd_seq.sv
// Scoreboard bench for sum_bin_to_bcd_seq: stimulus pushes expected results,
// a negedge monitor pops and checks value, latency, busy width and stability.
module tb_sum_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  logic [11:0] exp_q[$];
  int unsigned e0_q[$];
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned pushed = 0;
  int          checks = 0;
  int          errors = 0;

  logic [11:0] prev_bcd = '0;
  logic        rst_prev = 1'b1;
  int unsigned busy_run = 0;
  logic [11:0] mon_exp;
  int unsigned mon_e0;

  sum_bin_to_bcd_seq #(.WIDTH(9), .DIGITS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done actual=done required=no_done bcd=%0h", bcd);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_e0  = e0_q.pop_front();
        chk("bcd_value", {20'd0, bcd}, {20'd0, mon_exp});
        chk("done_latency", cyc - mon_e0, 32'd10);
      end
    end
    if (!done && !rst && !rst_prev && bcd !== prev_bcd)
      chk("bcd_stable", {20'd0, bcd}, {20'd0, prev_bcd});
    if (busy) begin
      busy_run++;
    end else if (busy_run != 0) begin
      if (!rst_prev) chk("busy_width", busy_run, 32'd9);
      busy_run = 0;
    end
    prev_bcd = bcd;
    rst_prev = rst;
  end

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=pending%0d required=0", exp_q.size());
      exp_q.delete();
      e0_q.delete();
    end
  endtask

  // Called in the drive phase (2 time units after a rising edge).
  task automatic run(input logic [8:0] v, input logic [11:0] e);
    bin   = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    e0_q.push_back(cyc);
    pushed++;
    #1 start = 1'b0;
    wait_drain();
  endtask

  function automatic logic [11:0] ref_bcd(input int unsigned v);
    ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  initial begin
    logic [7:0]  a, b;
    logic [8:0]  sum;
    int unsigned sweep_base;

    rst = 1'b1; start = 1'b0; bin = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_bcd", {20'd0, bcd}, 32'd0);
    #1 rst = 1'b0;

    // 1, 2: basic and boundary values
    run(9'd0,   12'h000);
    run(9'd510, 12'h510);
    run(9'd255, 12'h255);
    run(9'd100, 12'h100);
    run(9'd511, 12'h511);

    // 3: start re-pulsed with new bin while shifting is ignored
    bin = 9'd37; start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(12'h037); e0_q.push_back(cyc); pushed++;
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 start = 1'b1; bin = 9'd499;
    @(posedge clk);
    #2 start = 1'b0;
    wait_drain();
    repeat (15) @(posedge clk);
    #2;

    // 4: start held high gives back-to-back conversions, second accepted at E11
    bin = 9'd1; start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(12'h001); e0_q.push_back(cyc); pushed++;
    #1 bin = 9'd9;
    repeat (11) @(posedge clk);
    #1;
    exp_q.push_back(12'h009); e0_q.push_back(cyc); pushed++;
    #1 start = 1'b0;
    wait_drain();

    // 5: reset at E5 aborts a conversion and clears the result
    bin = 9'd123; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_bcd", {20'd0, bcd}, 32'd0);
    #1 rst = 1'b0;
    run(9'd456, 12'h456);

    // 6: full sweep with bin taken from an 8-bit adder sum (511 driven directly)
    sweep_base = done_cnt;
    for (int unsigned v = 0; v < 512; v++) begin
      if (v <= 510) begin
        a = (v > 255) ? 8'd255 : 8'(v);
        b = 8'(v - int'(a));
        sum = {1'b0, a} + {1'b0, b};
      end else begin
        sum = 9'd511;
      end
      run(sum, ref_bcd(v));
    end
    chk("sweep_done_count", done_cnt - sweep_base, 32'd512);

    repeat (5) @(posedge clk);
    #2;
    chk("total_done_count", done_cnt, pushed);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
